// File: rtl/apb_mem_slave_v2.sv
// apb_mem_slave_v2: parametrised APB4 memory slave with programmable wait states,
// byte strobes and an error response for out-of-range word addresses.
// Optional feature macro: APB_MEM_WPROT_EN. When it is defined, writes to words
// [0, WPROT_LIMIT) complete with PSLVERR=1 and leave memory untouched.
// PREADY, PSLVERR and PRDATA are all driven straight from flops.
module apb_mem_slave_v2 #(
    parameter int unsigned ADDR_WIDTH  = 4,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned WPROT_LIMIT = 4
) (
    input  logic                    PCLK,
    input  logic                    RESET,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic                    PREADY,
    output logic                    PSLVERR,
    output logic [DATA_WIDTH-1:0]   PRDATA
);

    localparam int unsigned NBYTES = DATA_WIDTH / 8;
    localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = 4;

    // One extra bit so DEPTH == 2**ADDR_WIDTH is representable.
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] WPROT_L = (ADDR_WIDTH + 1)'(WPROT_LIMIT);

    // The first ACCESS cycle is already a wait cycle, so the counter is loaded
    // with WAIT_STATES-1 and READY follows the cycle in which it reads zero.
    localparam logic [CNT_W-1:0] WAIT_LOAD =
        (WAIT_STATES == 0) ? '0 : CNT_W'(WAIT_STATES - 1);

`ifdef APB_MEM_WPROT_EN
    localparam logic WPROT_ON = 1'b1;
`else
    localparam logic WPROT_ON = 1'b0;
`endif

    // The SETUP bus cycle is recognised while in IDLE. This lets a zero-wait
    // access raise the registered PREADY in the very next cycle, which gives the
    // standard two-cycle APB transfer.
    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_READY
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        wcnt_q, wcnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    write_q, write_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [NBYTES-1:0]       strb_q, strb_d;
    logic                    pready_q, pready_d;
    logic                    pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic                    complete;
    logic                    range_err;
    logic                    prot_err;
    logic [IDX_W-1:0]        rd_idx;
    logic [IDX_W-1:0]        wr_idx;

    assign wr_idx = IDX_W'(addr_q);

    // Next-state logic: sequence the transfer and form the registered response.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can leave
        // a value unassigned and infer a latch.
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        addr_d    = addr_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = prdata_q;
        complete  = 1'b0;
        range_err = 1'b0;
        prot_err  = 1'b0;
        rd_idx    = '0;

        case (state_q)
            S_IDLE: begin
                if (PSEL && !PENABLE) begin
                    // Capture the transfer in its SETUP cycle. Later bus changes are ignored.
                    addr_d  = PADDR;
                    write_d = PWRITE;
                    wdata_d = PWDATA;
                    strb_d  = PSTRB;
                    if (WAIT_STATES == 0) begin
                        state_d  = S_READY;
                        complete = 1'b1;
                    end else begin
                        state_d = S_ACCESS;
                        wcnt_d  = WAIT_LOAD;
                    end
                end
            end
            S_ACCESS: begin
                if (!(PSEL && PENABLE)) begin
                    // Master aborted before PREADY. Drop the transfer silently.
                    state_d = S_IDLE;
                end else if (wcnt_q == '0) begin
                    state_d  = S_READY;
                    complete = 1'b1;
                end else begin
                    wcnt_d = wcnt_q - 1'b1;
                end
            end
            S_READY: begin
                // A back-to-back SETUP is seen next cycle from IDLE.
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (complete) begin
            range_err = ({1'b0, addr_d} >= DEPTH_L);
            prot_err  = WPROT_ON && write_d && ({1'b0, addr_d} < WPROT_L);
            rd_idx    = IDX_W'(addr_d);
            pready_d  = 1'b1;
            pslverr_d = range_err || prot_err;
            if (!write_d) begin
                prdata_d = range_err ? '0 : mem_q[rd_idx];
            end
        end
    end

    // Control, captured-transfer and output registers.
    always_ff @(posedge PCLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            wcnt_q    <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            strb_q    <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments, so every flop
            // samples the pre-edge values of the others.
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
        end
    end

    // Storage array: commit a strobed write on the edge that ends the PREADY cycle.
    always_ff @(posedge PCLK or posedge RESET) begin
        if (RESET) begin
            // NOTE: clearing the whole array on reset defines its contents after reset,
            // but it forces the array into flops instead of a RAM macro.
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (state_q == S_READY && write_q && !pslverr_q) begin
            for (int unsigned k = 0; k < NBYTES; k++) begin
                if (strb_q[k]) begin
                    mem_q[wr_idx][8*k +: 8] <= wdata_q[8*k +: 8];
                end
            end
        end
    end

    assign PREADY  = pready_q;
    assign PSLVERR = pslverr_q;
    assign PRDATA  = prdata_q;

endmodule

// File: tb/tb_apb_mem_slave_v2.sv
// Bench for apb_mem_slave_v2. There are two instances:
//   dut0: 32-bit data, DEPTH=12, no wait states (strobes, range errors, reset)
//   dut1: 8-bit data, DEPTH=16, WAIT_STATES=3 (wait timing, abort, protection)
// The stimulus pushes each expected response into a per-instance queue. A monitor
// pops the queue and compares whenever that instance raises PREADY.
module tb_apb_mem_slave_v2;

`ifdef APB_MEM_WPROT_EN
    localparam bit WP = 1'b1;
`else
    localparam bit WP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        psel0, psel1, penable, pwrite;
    logic [3:0]  paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pready0, pslverr0, pready1, pslverr1;
    logic [31:0] prdata0;
    logic [7:0]  prdata1;

    typedef struct {
        string       name;
        logic        is_write;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    apb_mem_slave_v2 #(
        .ADDR_WIDTH(4), .DATA_WIDTH(32), .DEPTH(12), .WAIT_STATES(0), .WPROT_LIMIT(4)
    ) dut0 (
        .PCLK(clk), .RESET(rst), .PSEL(psel0), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
        .PREADY(pready0), .PSLVERR(pslverr0), .PRDATA(prdata0)
    );

    apb_mem_slave_v2 #(
        .ADDR_WIDTH(4), .DATA_WIDTH(8), .DEPTH(16), .WAIT_STATES(3), .WPROT_LIMIT(4)
    ) dut1 (
        .PCLK(clk), .RESET(rst), .PSEL(psel1), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata[7:0]), .PSTRB(pstrb[0:0]),
        .PREADY(pready1), .PSLVERR(pslverr1), .PRDATA(prdata1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic ready_of(input int d);
        return (d == 0) ? pready0 : pready1;
    endfunction

    // Monitor for dut0: score each completion against the oldest expectation.
    always @(negedge clk) begin
        if (!rst) begin
            check("d0 pslverr without pready", 32'(pslverr0 & ~pready0), 32'd0);
            if (pready0) begin
                check("d0 expectation queued at pready", 32'(q0.size() != 0), 32'd1);
                if (q0.size() != 0) begin
                    exp_t e;
                    e = q0.pop_front();
                    check({e.name, " pslverr"}, 32'(pslverr0), 32'(e.err));
                    if (!e.is_write) check({e.name, " prdata"}, prdata0, e.rdata);
                end
            end
        end
    end

    // Monitor for dut1.
    always @(negedge clk) begin
        if (!rst) begin
            check("d1 pslverr without pready", 32'(pslverr1 & ~pready1), 32'd0);
            if (pready1) begin
                check("d1 expectation queued at pready", 32'(q1.size() != 0), 32'd1);
                if (q1.size() != 0) begin
                    exp_t e;
                    e = q1.pop_front();
                    check({e.name, " pslverr"}, 32'(pslverr1), 32'(e.err));
                    if (!e.is_write) check({e.name, " prdata"}, 32'(prdata1), e.rdata);
                end
            end
        end
    end

    // One APB transfer. It starts in the cycle after the call, so consecutive
    // calls run back-to-back. Address and data are scrambled in ACCESS to confirm
    // they are sampled only in SETUP.
    task automatic xfer(input int d, input string name, input logic wr, input logic [3:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        input logic exp_err, input logic [31:0] exp_rdata);
        exp_t e;
        int   cyc;
        int   exp_lat;
        e.name = name; e.is_write = wr; e.err = exp_err; e.rdata = exp_rdata;
        if (d == 0) q0.push_back(e); else q1.push_back(e);
        exp_lat = (d == 0) ? 1 : 4;
        @(posedge clk); #1;
        psel0 = (d == 0); psel1 = (d == 1); penable = 1'b0;
        pwrite = wr; paddr = addr; pwdata = wdata; pstrb = strb;
        @(posedge clk); #1;
        penable = 1'b1;
        paddr = ~addr; pwdata = ~wdata; pstrb = ~strb;
        cyc = 1;
        @(negedge clk);
        while (!ready_of(d) && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check({name, " latency"}, 32'(cyc), 32'(exp_lat));
    endtask

    task automatic bus_idle();
        @(posedge clk); #1;
        psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset d0 pready",  32'(pready0),  32'd0);
        check("reset d0 pslverr", 32'(pslverr0), 32'd0);
        check("reset d0 prdata",  prdata0,       32'd0);
        check("reset d1 pready",  32'(pready1),  32'd0);
        check("reset d1 prdata",  32'(prdata1),  32'd0);
        rst = 1'b0;

        // Basic write/read. Address 3 is protected only when the feature is built in.
        xfer(0, "d0 w a3", 1'b1, 4'd3, 32'h0000005A, 4'hF, WP, 32'h0);
        xfer(0, "d0 r a3", 1'b0, 4'd3, 32'h0, 4'h0, 1'b0, WP ? 32'h0 : 32'h0000005A);
        // Byte strobes, plus the PSTRB=0 no-op write.
        xfer(0, "d0 w a5 ones",  1'b1, 4'd5, 32'hFFFFFFFF, 4'hF, 1'b0, 32'h0);
        xfer(0, "d0 w a5 s0101", 1'b1, 4'd5, 32'h12345678, 4'h5, 1'b0, 32'h0);
        xfer(0, "d0 r a5",       1'b0, 4'd5, 32'h0, 4'h0, 1'b0, 32'hFF34FF78);
        xfer(0, "d0 w a5 s0000", 1'b1, 4'd5, 32'h00000000, 4'h0, 1'b0, 32'h0);
        xfer(0, "d0 r a5 again", 1'b0, 4'd5, 32'h0, 4'h0, 1'b0, 32'hFF34FF78);
        // Range boundary at DEPTH=12.
        xfer(0, "d0 r a13",  1'b0, 4'd13, 32'h0, 4'h0, 1'b1, 32'h0);
        xfer(0, "d0 w a11",  1'b1, 4'd11, 32'hCAFE0011, 4'hF, 1'b0, 32'h0);
        xfer(0, "d0 w a12",  1'b1, 4'd12, 32'hBAD0BAD0, 4'hF, 1'b1, 32'h0);
        xfer(0, "d0 r a12",  1'b0, 4'd12, 32'h0, 4'h0, 1'b1, 32'h0);
        xfer(0, "d0 r a11",  1'b0, 4'd11, 32'h0, 4'h0, 1'b0, 32'hCAFE0011);
        bus_idle();

        // Wait states and abort on dut1.
        xfer(1, "d1 w a7", 1'b1, 4'd7, 32'h11, 4'h1, 1'b0, 32'h0);
        xfer(1, "d1 r a7", 1'b0, 4'd7, 32'h0, 4'h0, 1'b0, 32'h11);
        bus_idle();
        @(posedge clk); #1;
        psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'd7; pwdata = 32'h33; pstrb = 4'h1;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel1 = 1'b0; penable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("d1 abort pready", 32'(pready1), 32'd0);
        end
        xfer(1, "d1 r a7 after abort", 1'b0, 4'd7, 32'h0, 4'h0, 1'b0, 32'h11);
        xfer(1, "d1 w a1", 1'b1, 4'd1, 32'hAA, 4'h1, WP, 32'h0);
        xfer(1, "d1 r a1", 1'b0, 4'd1, 32'h0, 4'h0, 1'b0, WP ? 32'h0 : 32'hAA);
        xfer(1, "d1 w a4", 1'b1, 4'd4, 32'hAA, 4'h1, 1'b0, 32'h0);
        xfer(1, "d1 r a4", 1'b0, 4'd4, 32'h0, 4'h0, 1'b0, 32'hAA);
        bus_idle();

        // Reset during the ACCESS/PREADY cycle of a write to address 2.
        @(posedge clk); #1;
        psel0 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'd2;
        pwdata = 32'h0BADF00D; pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        check("d0 pready before reset", 32'(pready0), 32'd1);
        rst = 1'b1;
        #1;
        check("mid reset d0 pready",  32'(pready0),  32'd0);
        check("mid reset d0 pslverr", 32'(pslverr0), 32'd0);
        check("mid reset d0 prdata",  prdata0,       32'd0);
        check("mid reset d1 prdata",  32'(prdata1),  32'd0);
        @(posedge clk); #1;
        psel0 = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        xfer(0, "d0 r a2 post reset", 1'b0, 4'd2, 32'h0, 4'h0, 1'b0, 32'h0);
        xfer(0, "d0 r a5 post reset", 1'b0, 4'd5, 32'h0, 4'h0, 1'b0, 32'h0);
        bus_idle();
        xfer(1, "d1 r a4 post reset", 1'b0, 4'd4, 32'h0, 4'h0, 1'b0, 32'h0);
        bus_idle();

        repeat (4) @(posedge clk);
        check("d0 queue drained", 32'(q0.size()), 32'd0);
        check("d1 queue drained", 32'(q1.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
